// File: rtl/register_file_if.sv
// rtl/register_file_if.sv - write/read port bundle for the two-read one-write register file
interface register_file_if #(
    parameter int N = 32
);
    logic         wr_ena;
    logic [4:0]   wr_addr;
    logic [N-1:0] wr_data;
    logic [4:0]   rd_addr0;
    logic [4:0]   rd_addr1;
    logic [N-1:0] rd_data0;
    logic [N-1:0] rd_data1;

    modport master (
        output wr_ena, wr_addr, wr_data, rd_addr0, rd_addr1,
        input  rd_data0, rd_data1
    );

    modport slave (
        input  wr_ena, wr_addr, wr_data, rd_addr0, rd_addr1,
        output rd_data0, rd_data1
    );
endinterface

// File: rtl/register_file.sv
// rtl/register_file.sv - RV32 architectural register file, x0 hardwired to zero
module register_file #(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           rst,
    register_file_if.slave bus
);
    // Entry i-1 holds architectural register xi; x0 has no storage.
    logic [N-1:0] regs_q [31];
    logic [N-1:0] regs_d [31];

    always_comb begin
        regs_d = regs_q;
        for (int i = 1; i < 32; i++) begin
            if (bus.wr_ena && bus.wr_addr == 5'(i)) begin
                regs_d[i-1] = bus.wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 31; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Reads see only committed state, so a same-cycle write is not bypassed.
    always_comb begin
        bus.rd_data0 = '0;
        for (int i = 1; i < 32; i++) begin
            if (bus.rd_addr0 == 5'(i)) begin
                bus.rd_data0 = regs_q[i-1];
            end
        end
    end

    always_comb begin
        bus.rd_data1 = '0;
        for (int i = 1; i < 32; i++) begin
            if (bus.rd_addr1 == 5'(i)) begin
                bus.rd_data1 = regs_q[i-1];
            end
        end
    end
endmodule

// File: doc/register_file.md
# register_file

Two-read, one-write architectural register file for the RV32 datapath. Holds 32 registers of N bits, with register x0 hardwired to zero. Sits directly upstream of the ALU operand select muxes: its two read ports feed the register-source inputs of the 4:1 operand muxes. The write-back result returns through the single write port on the clock edge.

## Interface
- N, 32, data width of every register and data port
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset; sampled on the rising edge of clk
- wr_ena  input  1  write enable for the write port
- wr_addr  input  5  destination register index
- wr_data  input  N  value to write
- rd_addr0  input  5  read port 0 register index (rs1)
- rd_addr1  input  5  read port 1 register index (rs2)
- rd_data0  output  N  contents of register rd_addr0
- rd_data1  output  N  contents of register rd_addr1

## Operation
- Storage: registers x1..x31, N bits each. x0 has no storage and always reads 0.
- Reads are combinational from current storage.
  - rd_data0 = (rd_addr0 == 0) ? 0 : reg[rd_addr0]; rd_data1 is the same with rd_addr1.
- Write: on a rising edge with rst=0, wr_ena=1 and wr_addr!=0, reg[wr_addr] <= wr_data.
  - A write with wr_addr=0 is discarded silently.
- No bypass. A read of the register being written in the same cycle returns the old value. The new value is visible after the edge.
- Both read ports may address the same register, including the one being written. Each returns the same value.
- Reset: on a rising edge with rst=1, all x1..x31 are set to 0.
  - rst has priority. A write presented in the same cycle as rst is dropped.
- Reset mid-operation: the register state after the reset edge is all-zero, whatever writes were pending. Normal writes resume on the first edge with rst=0.
- Unknown inputs: if wr_ena=0, wr_addr and wr_data are don't-care and must not alter state.

## Timing
- Read latency: 0 cycles (combinational address to data).
- Write latency: 1 edge. The value written at edge k appears on the read ports immediately after edge k.
- Outputs after reset: with any read address, rd_data0 and rd_data1 are 0 immediately after the reset edge. Before the first reset edge, contents are undefined, except that x0 reads 0.
- State changes only at rising clk edges. Nothing is asynchronous.
- Critical path: read address decode to the 32:1 data select. No write-to-read combinational path exists.

## Test plan
- Reset, then sweep rd_addr0/rd_addr1 over 0..31 -> every read returns 0x00000000.
- Write 0xDEADBEEF to x5 (wr_ena=1, wr_addr=5). Next cycle set rd_addr0=5, rd_addr1=5 -> both return 0xDEADBEEF. Same-cycle read during the write returns the prior value 0.
- Write 0x12345678 to x0 -> rd_data0 with rd_addr0=0 stays 0x00000000 in all subsequent cycles.
- Write 0xA5A5A5A5 to x7 with wr_ena=0 -> x7 still reads its previous value. Then write 0x00000001 to x31 with wr_ena=1 -> x31 reads 0x00000001 and x30 is unchanged.
- Fill x1..x31 with value i*0x01010101, then assert rst together with wr_ena=1, wr_addr=3, wr_data=0xFFFFFFFF -> after the edge, all registers including x3 read 0.
- Randomized: 1000 cycles of random writes and reads checked against a 32-entry reference model, with x0 held at 0 and reset pulsed at random -> zero mismatches.
